// File: rtl/sqrt_pkg.sv
// Shared types and helpers for the iterative square-root control path.
package sqrt_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        BOOT = 3'd1,
        CMP  = 3'd2,
        STEP = 3'd3,
        ADJ  = 3'd4,
        DONE = 3'd5
    } state_t;

    typedef enum logic {
        MODE_FLOOR = 1'b0,
        MODE_CEIL  = 1'b1
    } mode_t;

    // Largest root representable for a WIDTH-bit radicand: 2**(WIDTH/2)-1.
    function automatic int unsigned default_max_iter(input int unsigned width);
        return (32'd1 << (width / 32'd2)) - 32'd1;
    endfunction

endpackage

// File: rtl/sqrt_iter_counter.sv
// Saturating STEP counter with synchronous clear and terminal-count flag.
module sqrt_iter_counter #(
    parameter int unsigned MAX_ITER = 15,
    parameter int unsigned CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_tc_c
);

    logic [CNT_W-1:0] r_cnt;

    assign o_tc_c = (r_cnt == CNT_W'(MAX_ITER));
    assign o_cnt  = r_cnt;

    // Clear wins over increment; increment is blocked at terminal count so the value never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !o_tc_c) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sqrt_ctrl_param.sv
// Control FSM for the root/square register sqrt datapath: handshake, iteration bound, exact flag, ceil adjust.
module sqrt_ctrl_param
    import sqrt_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_ITER = default_max_iter(WIDTH),
    parameter int unsigned CNT_W    = $clog2(MAX_ITER + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic             cmp_le_i,
    input  logic             cmp_eq_i,
    output logic             boot_o,
    output logic             muxes_o,
    output logic             wr_root_o,
    output logic             wr_square_o,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             exact_o,
    output logic             err_o,
    output logic [CNT_W-1:0] iter_o
);

    state_t           r_state;
    state_t           w_state_nxt;
    mode_t            r_mode;
    mode_t            w_mode_nxt;
    logic             r_exact;
    logic             w_exact_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic             w_cnt_clr;
    logic             w_cnt_inc;
    logic             w_cnt_tc;
    logic [CNT_W-1:0] w_iter;
    logic             w_iter_zero;

    // Output strobes decoded from the next state so the registered copies track the current state.
    logic r_boot, r_muxes, r_wr_root, r_wr_square, r_ready, r_busy, r_done;
    logic w_boot, w_muxes, w_wr_root, w_wr_square, w_ready, w_busy, w_done;

    sqrt_iter_counter #(
        .MAX_ITER (MAX_ITER),
        .CNT_W    (CNT_W)
    ) u_iter_counter (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_cnt_clr),
        .i_inc  (w_cnt_inc),
        .o_cnt  (w_iter),
        .o_tc_c (w_cnt_tc)
    );

    assign w_iter_zero = (w_iter == '0);

    // Next-state, flag updates and strobe decode.
    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_exact_nxt = r_exact;
        w_err_nxt   = r_err;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_boot      = 1'b0;
        w_muxes     = 1'b0;
        w_wr_root   = 1'b0;
        w_wr_square = 1'b0;
        w_ready     = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;

        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_state_nxt = BOOT;
                    w_mode_nxt  = mode_t'(mode_i);
                end
            end
            BOOT: begin
                w_cnt_clr   = 1'b1;
                w_exact_nxt = 1'b0;
                w_err_nxt   = 1'b0;
                w_state_nxt = CMP;
            end
            CMP: begin
                if (cmp_le_i) begin
                    if (!w_cnt_tc) begin
                        w_state_nxt = STEP;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = DONE;
                    end
                end else if (w_iter_zero) begin
                    // (0+1)^2 > N only when N is zero, which is a perfect square.
                    w_exact_nxt = 1'b1;
                    w_state_nxt = DONE;
                end else if ((r_mode == MODE_CEIL) && !r_exact) begin
                    w_state_nxt = ADJ;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            STEP: begin
                w_cnt_inc   = 1'b1;
                // S == N before the step means the incremented root squares to N.
                w_exact_nxt = cmp_eq_i;
                w_state_nxt = CMP;
            end
            ADJ: begin
                w_state_nxt = DONE;
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        case (w_state_nxt)
            IDLE: begin
                w_ready = 1'b1;
            end
            BOOT: begin
                w_busy      = 1'b1;
                w_boot      = 1'b1;
                w_wr_root   = 1'b1;
                w_wr_square = 1'b1;
            end
            CMP: begin
                w_busy  = 1'b1;
                w_muxes = 1'b1;
            end
            STEP: begin
                w_busy      = 1'b1;
                w_muxes     = 1'b1;
                w_wr_root   = 1'b1;
                w_wr_square = 1'b1;
            end
            ADJ: begin
                w_busy    = 1'b1;
                w_muxes   = 1'b1;
                w_wr_root = 1'b1;
            end
            DONE: begin
                w_done = 1'b1;
            end
            default: begin
                w_ready = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latched mode and result flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode  <= MODE_FLOOR;
            r_exact <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_mode  <= w_mode_nxt;
            r_exact <= w_exact_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Registered datapath and handshake strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_boot      <= 1'b0;
            r_muxes     <= 1'b0;
            r_wr_root   <= 1'b0;
            r_wr_square <= 1'b0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_boot      <= w_boot;
            r_muxes     <= w_muxes;
            r_wr_root   <= w_wr_root;
            r_wr_square <= w_wr_square;
            r_ready     <= w_ready;
            r_busy      <= w_busy;
            r_done      <= w_done;
        end
    end

    assign boot_o      = r_boot;
    assign muxes_o     = r_muxes;
    assign wr_root_o   = r_wr_root;
    assign wr_square_o = r_wr_square;
    assign ready_o     = r_ready;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign exact_o     = r_exact;
    assign err_o       = r_err;
    assign iter_o      = w_iter;

endmodule

// File: tb/tb_sqrt_ctrl_param.sv
// Bench for sqrt_ctrl_param: behavioural root/square datapath plus a result scoreboard.
module tb_sqrt_ctrl_param;

    localparam int unsigned CNT_W = 4;
    localparam int MAXI = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start_i = 1'b0;
    logic mode_i = 1'b0;
    logic cmp_le_i, cmp_eq_i;
    logic boot_o, muxes_o, wr_root_o, wr_square_o, ready_o, busy_o, done_o, exact_o, err_o;
    logic [CNT_W-1:0] iter_o;

    typedef struct {
        int lat;
        int iter;
        int exact;
        int err;
        int root;
        int steps;
        int adj;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_fail = 0;
    int dp_r, dp_s;
    int dp_n = 0;
    bit force_le = 1'b0;
    int cyc = 0;
    int acc_cyc = 0;
    int accept_cnt = 0;
    int done_cnt = 0;
    int step_cnt = 0;
    int adj_cnt = 0;

    always #5 clk = ~clk;

    sqrt_ctrl_param #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .mode_i      (mode_i),
        .cmp_le_i    (cmp_le_i),
        .cmp_eq_i    (cmp_eq_i),
        .boot_o      (boot_o),
        .muxes_o     (muxes_o),
        .wr_root_o   (wr_root_o),
        .wr_square_o (wr_square_o),
        .ready_o     (ready_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .exact_o     (exact_o),
        .err_o       (err_o),
        .iter_o      (iter_o)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Datapath model: S tracks (R+1)^2.
    assign cmp_le_i = force_le ? 1'b1 : (dp_s <= dp_n);
    assign cmp_eq_i = (dp_s == dp_n);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            dp_r <= 0;
            dp_s <= 1;
        end else begin
            if (wr_root_o)   dp_r <= muxes_o ? dp_r + 1 : 0;
            if (wr_square_o) dp_s <= muxes_o ? dp_s + 2 * dp_r + 3 : 1;
        end
    end

    // Cycle counter and start-accept bookkeeping.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst && start_i && ready_o) begin
            acc_cyc    <= cyc;
            accept_cnt <= accept_cnt + 1;
        end
    end

    // Monitor: count strobes per run and compare results at done_o.
    always @(negedge clk) begin
        if (rst) begin
            if (boot_o) begin
                step_cnt = 0;
                adj_cnt  = 0;
            end
            if (wr_square_o && muxes_o) step_cnt++;
            if (wr_root_o && muxes_o && !wr_square_o) adj_cnt++;
            if (done_o) begin
                done_cnt++;
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("latency", cyc - acc_cyc, mon_e.lat);
                    check("iter",    int'(iter_o),  mon_e.iter);
                    check("exact",   int'(exact_o), mon_e.exact);
                    check("err",     int'(err_o),   mon_e.err);
                    check("root",    dp_r,          mon_e.root);
                    check("steps",   step_cnt,      mon_e.steps);
                    check("adj",     adj_cnt,       mon_e.adj);
                end
            end
        end
    end

    function automatic exp_t model(input int n, input bit ceil_m, input bit frc);
        exp_t e;
        int r;
        r = 0;
        if (frc) begin
            e.steps = MAXI;
            e.iter  = MAXI;
            e.err   = 1;
            e.root  = MAXI;
            e.exact = (MAXI * MAXI == n) ? 1 : 0;
            e.adj   = 0;
            e.lat   = 2 * MAXI + 3;
        end else begin
            while ((r + 1) * (r + 1) <= n) r++;
            e.steps = r;
            e.iter  = r;
            e.err   = 0;
            e.exact = (r * r == n) ? 1 : 0;
            e.adj   = (ceil_m && (r * r != n)) ? 1 : 0;
            e.root  = r + e.adj;
            e.lat   = 2 * r + 3 + e.adj;
        end
        return e;
    endfunction

    task automatic start_run(input int n, input bit m, input bit frc, input bit hold);
        @(negedge clk);
        for (int i = 0; i < 200 && !ready_o; i++) @(negedge clk);
        if (!ready_o) check("ready_timeout", 0, 1);
        dp_n     = n;
        force_le = frc;
        mode_i   = m;
        start_i  = 1'b1;
        sb_q.push_back(model(n, m, frc));
        @(negedge clk);
        // Flip mode after acceptance: the latched copy must be used.
        mode_i = ~m;
        if (!hold) start_i = 1'b0;
    endtask

    task automatic wait_done();
        int d0;
        bit seen;
        d0   = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (done_cnt != d0) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("done_timeout", 0, 1);
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic run(input int n, input bit m, input bit frc, input bit hold);
        start_run(n, m, frc, hold);
        wait_done();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"},  int'(ready_o),     1);
        check({tag, "_busy"},   int'(busy_o),      0);
        check({tag, "_done"},   int'(done_o),      0);
        check({tag, "_boot"},   int'(boot_o),      0);
        check({tag, "_muxes"},  int'(muxes_o),     0);
        check({tag, "_wrroot"}, int'(wr_root_o),   0);
        check({tag, "_wrsq"},   int'(wr_square_o), 0);
        check({tag, "_iter"},   int'(iter_o),      0);
        check({tag, "_exact"},  int'(exact_o),     0);
        check({tag, "_err"},    int'(err_o),       0);
    endtask

    initial begin
        int a0;
        int d0;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        rst = 1'b1;

        run(16, 1'b0, 1'b0, 1'b0);
        run(17, 1'b1, 1'b0, 1'b0);
        run(25, 1'b1, 1'b0, 1'b0);
        run(0,  1'b0, 1'b0, 1'b0);

        // start_i held high across the whole run.
        a0 = accept_cnt;
        run(9, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        check("hold_accepts", accept_cnt - a0, 1);

        // Extra start pulses while busy are ignored.
        a0 = accept_cnt;
        fork
            run(9, 1'b0, 1'b0, 1'b0);
            begin
                repeat (5) @(negedge clk);
                repeat (3) begin
                    start_i = 1'b1;
                    @(negedge clk);
                    start_i = 1'b0;
                    @(negedge clk);
                end
            end
        join
        repeat (2) @(negedge clk);
        check("busy_pulse_accepts", accept_cnt - a0, 1);

        // Stuck compare flag drives the iteration bound.
        run(16, 1'b0, 1'b1, 1'b0);

        // Asynchronous abort in the middle of a run.
        start_run(200, 1'b0, 1'b0, 1'b0);
        repeat (7) @(negedge clk);
        check("busy_before_rst", int'(busy_o), 1);
        check("iter_before_rst", int'(iter_o), 3);
        #2 rst = 1'b0;
        #1 check_reset_values("abort");
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        d0 = done_cnt;
        repeat (10) @(negedge clk);
        check("no_done_after_abort", done_cnt - d0, 0);

        run(200, 1'b0, 1'b0, 1'b0);
        run(255, 1'b1, 1'b0, 1'b0);
        run(225, 1'b1, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
